// File: rtl/hazard_control_unit.sv
// Hazard detection for a 5-stage MIPS-style pipeline: load-use and
// branch-operand stalls, HI/LO interlock against a multi-cycle mult/div
// unit, control-flow flushes, and stall/flush event counters.
module hazard_control_unit #(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  ID_RegRs,
  input  logic [4:0]  ID_RegRt,
  input  logic        ID_UsesRs,
  input  logic        ID_UsesRt,
  input  logic        ID_IsBranch,
  input  logic        ID_IsMulDiv,
  input  logic        ID_UsesHiLo,
  input  logic        BranchTaken,
  input  logic        Jump,
  input  logic        EX_RegWrite,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_Rd,
  input  logic        MEM_MemRead,
  input  logic [4:0]  MEM_Rd,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic        MulDivBusy,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
);

  localparam int unsigned CntW   = 4;
  localparam int unsigned CountW = 32;
  localparam logic [CntW-1:0] CntLoad = CntW'(MULDIV_CYCLES);

  typedef enum logic {IDLE, BUSY} mdState_t;

  mdState_t        mdState;
  logic [CntW-1:0] cnt;

  logic exHit;
  logic memHit;
  logic loadUseStall;
  logic branchStall;
  logic hiLoStall;
  logic stall;

  // Source-register match against a producer; r0 never matches
  assign exHit  = (EX_Rd != 5'd0) &&
                  ((ID_UsesRs && (ID_RegRs == EX_Rd)) ||
                   (ID_UsesRt && (ID_RegRt == EX_Rd)));
  assign memHit = (MEM_Rd != 5'd0) &&
                  ((ID_UsesRs && (ID_RegRs == MEM_Rd)) ||
                   (ID_UsesRt && (ID_RegRt == MEM_Rd)));

  // A load reaching a branch stalls twice: once in EX, once in MEM
  assign loadUseStall = EX_MemRead && exHit;
  assign branchStall  = ID_IsBranch &&
                        ((EX_RegWrite && exHit) || (MEM_MemRead && memHit));
  assign hiLoStall    = MulDivBusy && ID_UsesHiLo;
  assign stall        = loadUseStall || branchStall || hiLoStall;

  // Zero-latency pipeline control; a stalled branch has no valid outcome yet
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    if (stall) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else if (Jump || (ID_IsBranch && BranchTaken)) begin
      IF_ID_Flush = 1'b1;
    end
  end

  // Mult/div occupancy FSM; busy lasts exactly MULDIV_CYCLES cycles
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mdState    <= IDLE;
      cnt        <= '0;
      MulDivBusy <= 1'b0;
    end else begin
      case (mdState)
        IDLE: begin
          if (ID_IsMulDiv && !stall) begin
            mdState    <= BUSY;
            cnt        <= CntLoad;
            MulDivBusy <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt == CntW'(1)) begin
            mdState    <= IDLE;
            cnt        <= '0;
            MulDivBusy <= 1'b0;
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        default: begin
          mdState    <= IDLE;
          cnt        <= '0;
          MulDivBusy <= 1'b0;
        end
      endcase
    end
  end

  // Free-running event counters, wrapping modulo 2^32
  always_ff @(posedge Clk) begin
    if (Reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      StallCount <= StallCount + CountW'(stall);
      FlushCount <= FlushCount + CountW'(IF_ID_Flush);
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: vector table, directed
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_hazard_control_unit;

  localparam int unsigned MDC = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  ID_RegRs, ID_RegRt, EX_Rd, MEM_Rd;
  logic        ID_UsesRs, ID_UsesRt, ID_IsBranch, ID_IsMulDiv, ID_UsesHiLo;
  logic        BranchTaken, Jump, EX_RegWrite, EX_MemRead, MEM_MemRead;
  logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MulDivBusy;
  logic [31:0] StallCount, FlushCount;

  hazard_control_unit #(.MULDIV_CYCLES(MDC)) dut (
    .Clk(Clk), .Reset(Reset),
    .ID_RegRs(ID_RegRs), .ID_RegRt(ID_RegRt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_IsBranch(ID_IsBranch), .ID_IsMulDiv(ID_IsMulDiv),
    .ID_UsesHiLo(ID_UsesHiLo), .BranchTaken(BranchTaken), .Jump(Jump),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd),
    .MEM_MemRead(MEM_MemRead), .MEM_Rd(MEM_Rd),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Bubble(ID_EX_Bubble), .MulDivBusy(MulDivBusy),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       reset;
    logic [4:0] rs, rt;
    logic       usesRs, usesRt, isBranch, isMulDiv, usesHiLo, brTaken, jump;
    logic       exRegWrite, exMemRead;
    logic [4:0] exRd;
    logic       memMemRead;
    logic [4:0] memRd;
  } in_t;

  typedef struct {
    in_t  in;
    logic expStall;
    logic expFlush;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  int          mdLeft = 0;     // remaining busy cycles of the mult/div unit
  int unsigned mStall = 0;
  int unsigned mFlush = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic in_t nop();
    in_t i;
    i = '{reset: 1'b0, rs: 5'd0, rt: 5'd0, usesRs: 1'b0, usesRt: 1'b0,
          isBranch: 1'b0, isMulDiv: 1'b0, usesHiLo: 1'b0, brTaken: 1'b0,
          jump: 1'b0, exRegWrite: 1'b0, exMemRead: 1'b0, exRd: 5'd0,
          memMemRead: 1'b0, memRd: 5'd0};
    return i;
  endfunction

  // Does the ID instruction read register x (r0 excluded)?
  function automatic logic reads(input in_t i, input logic [4:0] x);
    if (x == 5'd0) return 1'b0;
    return (i.usesRs && i.rs == x) || (i.usesRt && i.rt == x);
  endfunction

  function automatic logic modelStall(input in_t i);
    logic lu, br, hl;
    lu = i.exMemRead && reads(i, i.exRd);
    br = i.isBranch && ((i.exRegWrite && reads(i, i.exRd)) ||
                        (i.memMemRead && reads(i, i.memRd)));
    hl = (mdLeft > 0) && i.usesHiLo;
    return lu || br || hl;
  endfunction

  task automatic drive(input in_t i);
    Reset = i.reset; ID_RegRs = i.rs; ID_RegRt = i.rt;
    ID_UsesRs = i.usesRs; ID_UsesRt = i.usesRt; ID_IsBranch = i.isBranch;
    ID_IsMulDiv = i.isMulDiv; ID_UsesHiLo = i.usesHiLo;
    BranchTaken = i.brTaken; Jump = i.jump;
    EX_RegWrite = i.exRegWrite; EX_MemRead = i.exMemRead; EX_Rd = i.exRd;
    MEM_MemRead = i.memMemRead; MEM_Rd = i.memRd;
  endtask

  // One clock: drive, check against the model mid-cycle, then advance the model
  task automatic cycle(input in_t i, input string tag, output logic sStall, output logic sFlush);
    logic es, ef;
    drive(i);
    @(negedge Clk);
    es = modelStall(i);
    ef = !es && (i.jump || (i.isBranch && i.brTaken));
    chk({tag, ".PCWrite"},     32'(PCWrite),      32'(!es));
    chk({tag, ".IF_ID_Write"}, 32'(IF_ID_Write),  32'(!es));
    chk({tag, ".ID_EX_Bubble"},32'(ID_EX_Bubble), 32'(es));
    chk({tag, ".IF_ID_Flush"}, 32'(IF_ID_Flush),  32'(ef));
    chk({tag, ".MulDivBusy"},  32'(MulDivBusy),   32'(mdLeft > 0));
    chk({tag, ".StallCount"},  StallCount,        mStall);
    chk({tag, ".FlushCount"},  FlushCount,        mFlush);
    sStall = ID_EX_Bubble;
    sFlush = IF_ID_Flush;
    @(posedge Clk);
    if (i.reset) begin
      mdLeft = 0; mStall = 0; mFlush = 0;
    end else begin
      if (mdLeft > 0) mdLeft--;
      else if (i.isMulDiv && !es) mdLeft = MDC;
      if (es) mStall++;
      if (ef) mFlush++;
    end
    #1;
  endtask

  task automatic doReset();
    in_t i;
    logic s, f;
    i = nop();
    i.reset = 1'b1;
    cycle(i, "rst", s, f);
  endtask

  vec_t tbl[8];

  initial begin
    in_t  i;
    logic s, f;

    // Bring up: registered state is unknown until the first reset edge
    i = nop(); i.reset = 1'b1;
    drive(i);
    @(posedge Clk); #1;

    // Reset state visible after reset edge
    chk("reset.MulDivBusy", 32'(MulDivBusy), 32'd0);
    chk("reset.StallCount", StallCount, 32'd0);
    chk("reset.FlushCount", FlushCount, 32'd0);

    // Single-cycle vector table (mult/div unit idle throughout)
    for (int k = 0; k < 8; k++) tbl[k].in = nop();
    tbl[0].expStall = 1'b0; tbl[0].expFlush = 1'b0;
    tbl[1].in.exMemRead = 1'b1; tbl[1].in.exRd = 5'd8; tbl[1].in.rt = 5'd8; tbl[1].in.usesRt = 1'b1;
    tbl[1].expStall = 1'b1; tbl[1].expFlush = 1'b0;
    tbl[2].in.exMemRead = 1'b1; tbl[2].in.exRd = 5'd8; tbl[2].in.rt = 5'd8; tbl[2].in.usesRt = 1'b0;
    tbl[2].expStall = 1'b0; tbl[2].expFlush = 1'b0;
    tbl[3].in.exRegWrite = 1'b1; tbl[3].in.exRd = 5'd5; tbl[3].in.rs = 5'd5; tbl[3].in.usesRs = 1'b1;
    tbl[3].expStall = 1'b0; tbl[3].expFlush = 1'b0;
    tbl[4].in = tbl[3].in; tbl[4].in.isBranch = 1'b1; tbl[4].in.brTaken = 1'b1;
    tbl[4].expStall = 1'b1; tbl[4].expFlush = 1'b0;
    tbl[5].in.isBranch = 1'b1; tbl[5].in.brTaken = 1'b1; tbl[5].in.exRegWrite = 1'b1;
    tbl[5].in.exMemRead = 1'b1; tbl[5].in.exRd = 5'd0; tbl[5].in.usesRs = 1'b1;
    tbl[5].in.usesRt = 1'b1; tbl[5].in.memMemRead = 1'b1;
    tbl[5].expStall = 1'b0; tbl[5].expFlush = 1'b1;
    tbl[6].in.jump = 1'b1; tbl[6].in.usesHiLo = 1'b1;
    tbl[6].expStall = 1'b0; tbl[6].expFlush = 1'b1;
    tbl[7].in.memMemRead = 1'b1; tbl[7].in.memRd = 5'd12; tbl[7].in.rt = 5'd12;
    tbl[7].in.usesRt = 1'b1; tbl[7].in.isBranch = 1'b1;
    tbl[7].expStall = 1'b1; tbl[7].expFlush = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cycle(tbl[k].in, $sformatf("tbl%0d", k), s, f);
      chk($sformatf("tbl%0d.stall", k), 32'(s), 32'(tbl[k].expStall));
      chk($sformatf("tbl%0d.flush", k), 32'(f), 32'(tbl[k].expFlush));
    end

    // Load-use on rt: one stall cycle, counter 0 -> 1
    doReset();
    i = nop(); i.exMemRead = 1'b1; i.exRd = 5'd8; i.rt = 5'd8; i.usesRt = 1'b1;
    cycle(i, "lu", s, f);
    chk("lu.stall", 32'(s), 32'd1);
    chk("lu.StallCount", StallCount, 32'd1);

    // Load r9 then beq r9: two stall cycles, then taken branch flushes
    doReset();
    i = nop(); i.isBranch = 1'b1; i.brTaken = 1'b1; i.rs = 5'd9; i.usesRs = 1'b1;
    i.exMemRead = 1'b1; i.exRegWrite = 1'b1; i.exRd = 5'd9;
    cycle(i, "ldbr.a", s, f);
    chk("ldbr.a.stall", 32'(s), 32'd1); chk("ldbr.a.flush", 32'(f), 32'd0);
    i.exMemRead = 1'b0; i.exRegWrite = 1'b0; i.exRd = 5'd0;
    i.memMemRead = 1'b1; i.memRd = 5'd9;
    cycle(i, "ldbr.b", s, f);
    chk("ldbr.b.stall", 32'(s), 32'd1); chk("ldbr.b.flush", 32'(f), 32'd0);
    i.memMemRead = 1'b0; i.memRd = 5'd0;
    cycle(i, "ldbr.c", s, f);
    chk("ldbr.c.stall", 32'(s), 32'd0); chk("ldbr.c.flush", 32'(f), 32'd1);
    chk("ldbr.FlushCount", FlushCount, 32'd1);
    chk("ldbr.StallCount", StallCount, 32'd2);

    // r0 as branch source never stalls
    i = nop(); i.exRegWrite = 1'b1; i.exRd = 5'd0; i.isBranch = 1'b1; i.rs = 5'd0; i.usesRs = 1'b1;
    cycle(i, "r0br", s, f);
    chk("r0br.stall", 32'(s), 32'd0);

    // mult accepted, then mflo stalls for the busy window and is released
    doReset();
    i = nop(); i.isMulDiv = 1'b1; i.usesHiLo = 1'b1;
    cycle(i, "mult", s, f);
    chk("mult.stall", 32'(s), 32'd0);
    i = nop(); i.usesHiLo = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("mflo%0d.busy", k), 32'(MulDivBusy), 32'(k < 4));
      cycle(i, $sformatf("mflo%0d", k), s, f);
      chk($sformatf("mflo%0d.stall", k), 32'(s), 32'(k < 4));
    end

    // Reset mid-busy (Cnt=2) clears the unit and counters
    doReset();
    i = nop(); i.isMulDiv = 1'b1; i.usesHiLo = 1'b1;
    cycle(i, "mr.mult", s, f);
    i = nop(); i.usesHiLo = 1'b1;
    cycle(i, "mr.c4", s, f);
    cycle(i, "mr.c3", s, f);
    i.reset = 1'b1;
    cycle(i, "mr.c2", s, f);
    chk("mr.c2.stall", 32'(s), 32'd1);
    chk("mr.busy", 32'(MulDivBusy), 32'd0);
    chk("mr.StallCount", StallCount, 32'd0);
    chk("mr.FlushCount", FlushCount, 32'd0);
    i.reset = 1'b0;
    cycle(i, "mr.mflo", s, f);
    chk("mr.mflo.stall", 32'(s), 32'd0);

    // Jump with a load-use hit waits, then flushes once the hit clears
    doReset();
    i = nop(); i.jump = 1'b1; i.exMemRead = 1'b1; i.exRd = 5'd3; i.rs = 5'd3; i.usesRs = 1'b1;
    cycle(i, "jlu.a", s, f);
    chk("jlu.a.stall", 32'(s), 32'd1); chk("jlu.a.flush", 32'(f), 32'd0);
    i.exMemRead = 1'b0;
    cycle(i, "jlu.b", s, f);
    chk("jlu.b.stall", 32'(s), 32'd0); chk("jlu.b.flush", 32'(f), 32'd1);

    // Randomized traffic with small register numbers to provoke hits
    for (int n = 0; n < 1500; n++) begin
      i.reset      = ($urandom_range(0, 63) == 0);
      i.rs         = 5'($urandom_range(0, 3));
      i.rt         = 5'($urandom_range(0, 3));
      i.usesRs     = 1'($urandom);
      i.usesRt     = 1'($urandom);
      i.isBranch   = 1'($urandom);
      i.isMulDiv   = ($urandom_range(0, 7) == 0);
      i.usesHiLo   = i.isMulDiv || ($urandom_range(0, 3) == 0);
      i.brTaken    = 1'($urandom);
      i.jump       = ($urandom_range(0, 7) == 0);
      i.exRegWrite = 1'($urandom);
      i.exMemRead  = 1'($urandom);
      i.exRd       = 5'($urandom_range(0, 3));
      i.memMemRead = 1'($urandom);
      i.memRd      = 5'($urandom_range(0, 3));
      cycle(i, "rnd", s, f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
